// File: rtl/int_div_multi.sv
// Multi-channel runtime-programmable integer clock divider.
// Divisor changes and enable changes only take effect at period boundaries.
module int_div_multi #(
    parameter int CH      = 4,
    parameter int W       = 32,
    parameter int DEF_DIV = 48000000
) (
    input  logic            clock,
    input  logic            rst_n,
    input  logic [CH-1:0]   en,
    input  logic [CH*W-1:0] div_in,
    input  logic [CH-1:0]   div_load,
    output logic [CH-1:0]   clk_out,
    output logic [CH-1:0]   tick,
    output logic [CH-1:0]   active
);

    localparam logic [W-1:0] DEF_VAL = W'(DEF_DIV);
    localparam logic [W-1:0] ONE     = W'(1);

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [W-1:0] s_q, d_q, c_q;
        logic         p_q, n_q, t_q, r_q;
        logic [W-1:0] s_eff, d_nxt, c_nxt, h_nxt;
        logic         r_nxt, boundary;

        // NOTE: every always_comb output gets a default first so no path infers a latch.
        always_comb begin
            s_eff    = div_load[k] ? div_in[k*W +: W] : s_q;
            boundary = !r_q || (c_q == d_q - ONE);
            d_nxt    = d_q;
            c_nxt    = c_q + ONE;
            r_nxt    = r_q;
            if (boundary) begin
                // A load in the boundary cycle writes straight through to the next period.
                d_nxt = s_eff;
                c_nxt = '0;
                r_nxt = en[k] && (s_eff != '0);
            end
            h_nxt = d_nxt >> 1;
        end

        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        always_ff @(posedge clock) begin
            if (!rst_n) begin
                s_q <= DEF_VAL;
                d_q <= DEF_VAL;
                c_q <= '0;
                p_q <= 1'b0;
                t_q <= 1'b0;
                r_q <= 1'b0;
            end else begin
                if (div_load[k]) s_q <= div_in[k*W +: W];
                d_q <= d_nxt;
                c_q <= c_nxt;
                r_q <= r_nxt;
                // P and T are precomputed from the next count so they align with C.
                p_q <= r_nxt && (c_nxt >= h_nxt);
                t_q <= r_nxt && (c_nxt == h_nxt);
            end
        end

        // Half-cycle delayed copy of P; ANDing it with P trims odd periods to 50% duty.
        always_ff @(negedge clock) begin
            if (!rst_n) n_q <= 1'b0;
            else        n_q <= p_q;
        end

        assign clk_out[k] = !r_q        ? 1'b0 :
                            (d_q == ONE) ? clock :
                            d_q[0]       ? (p_q & n_q) : p_q;
        assign tick[k]    = t_q;
        assign active[k]  = r_q;
    end

endmodule
